lif_synapse_loader: RTL and testbench
=====================================

// Module: lif_synapse_loader
// PURPOSE
//  Upstream feeder for neuron_lif: assembles SYNAPSES-wide input-spike and weight vectors from a narrow
//  valid/ready byte stream (TT-style IO), double-buffers them, and issues a one-cycle enable per input frame.
//  Drives neuron_lif .inputs/.weights/.enable directly; weights persist across many input frames.
// PARAMETERS
//  SYNAPSES    32  neuron fan-in; width of inputs_out/weights_out; must be a multiple of BUS_WIDTH
//  BUS_WIDTH   8   stream beat width
//  COUNT_BITS  8   width of frame_count
//  (derived) BEATS = SYNAPSES/BUS_WIDTH beats per frame; BEAT_BITS = max(1,$clog2(BEATS))
// PORTS
//  clk           in   1          clock, all state on rising edge
//  reset         in   1          asynchronous, active-high; clears all state
//  in_data       in   BUS_WIDTH  stream beat
//  in_kind       in   1          0 = input-spike beat, 1 = weight beat
//  in_valid      in   1          beat present
//  in_ready      out  1          beat accepted on edge where in_valid && in_ready
//  flush         in   1          sync: discard partial/pending frames of both kinds
//  hold          in   1          blocks commits while high (neuron frozen)
//  inputs_out    out  SYNAPSES   committed input vector -> neuron_lif.inputs
//  weights_out   out  SYNAPSES   committed weight vector -> neuron_lif.weights
//  neuron_enable out  1          one-cycle pulse per committed input frame -> neuron_lif.enable
//  frame_count   out  COUNT_BITS committed input frames, wraps 2^COUNT_BITS-1 -> 0
// BEHAVIOUR
//  Reset (async): staging regs, beat counters, pending flags, inputs_out, weights_out, frame_count = 0;
//   neuron_enable = 0; in_ready = 1 once reset is low. Reset mid-frame discards everything immediately.
//  Two independent assemblers (inputs, weights), each: BUS_WIDTH*BEATS staging reg, beat counter, pending flag.
//  Beat k of a frame (k = 0..BEATS-1) lands in staging bits [k*BUS_WIDTH +: BUS_WIDTH] (LSB beat first).
//  Accepted beat routes by in_kind; counter of the other kind is untouched (interleaving allowed).
//  Final beat (k = BEATS-1): counter wraps to 0, pending of that kind set on the same edge.
//  in_ready = !inputs_pending && !weights_pending && !flush (combinational).
//  Commit, evaluated every edge with hold == 0 and flush == 0:
//   - weights_pending -> weights_out <= staging_w; clear pending. No enable pulse.
//   - inputs_pending  -> inputs_out <= staging_i; clear pending; neuron_enable <= 1; frame_count += 1.
//   - both pending: both commit on the same edge; the pulse cycle presents the NEW weights.
//  neuron_enable is registered: high exactly the cycle after the commit edge, 0 otherwise.
//  Latency (hold low): last beat accepted on edge N -> commit edge N+1 -> neuron_enable high in cycle
//   after N+1 -> neuron samples on edge N+2. Max throughput: one input frame per BEATS+1 cycles.
//  hold high: pending frames wait, in_ready stays 0, outputs stable; commit on first edge with hold low.
//  flush high: both counters -> 0, both pending -> 0, beat on that edge dropped (in_ready = 0);
//   outputs, frame_count, in-flight neuron_enable pulse unaffected. flush wins over hold.
//  inputs_out/weights_out change only on commit edges; stable between commits.
// STRUCTURE
//  Shared package/header: KIND_INPUTS = 1'b0, KIND_WEIGHTS = 1'b1, BEATS/BEAT_BITS derivation function.
//  Sub-module lif_frame_assembler (WIDTH, BUS_WIDTH): staging reg, beat counter, pending flag,
//   ports beat_valid, beat_data, commit, flush -> frame_data, pending. Two instances.
//  Top: in_ready logic, commit control, output shadow regs, enable register, frame counter.
//  Elaboration check: SYNAPSES % BUS_WIDTH != 0 -> $error.
// TESTING (SYNAPSES=32, BUS_WIDTH=8)
//  1 kind=1 beats 11,22,33,44 hold=0 -> weights_out=0x44332211 one edge after last beat; neuron_enable stays 0.
//  2 then kind=0 beats AA,BB,CC,DD -> inputs_out=0xDDCCBBAA, single neuron_enable pulse, frame_count=1;
//    in_ready low exactly one cycle after last beat.
//  3 hold=1 over last input beat -> in_ready=0, no pulse for 5 cycles; hold=0 -> commit next edge, one pulse.
//  4 interleave: 2 input beats, 4 weight beats (0xF0F0F0F0), 2 input beats -> weights commit first;
//    pulse cycle shows weights_out=0xF0F0F0F0.
//  5 3 input beats, flush, then beats 01,02,03,04 -> inputs_out=0x04030201, frame_count +1 only.
//  6 async reset mid-frame and at frame_count=255 -> all outputs 0 without clock; 256 frames -> count wraps 0.

Source files
------------

// File: rtl/lif_synapse_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lif_synapse_loader_pkg
//  Description : Shared constants and helpers for the LIF synapse loader.
//                Stream-kind encodings and the beats-per-frame derivation
//                used by the top level and by the frame assemblers.
//  Revision    : 1.0  initial release
// ============================================================================
package lif_synapse_loader_pkg;

    // in_kind encoding of a stream beat
    localparam logic KIND_INPUTS  = 1'b0;
    localparam logic KIND_WEIGHTS = 1'b1;

    // Number of stream beats that make up one vector of the given width.
    function automatic int beats_of(input int vec_width, input int bus_width);
        return vec_width / bus_width;
    endfunction

    // Width of a beat counter; never narrower than one bit so a
    // single-beat frame still has a legal counter.
    function automatic int beat_bits_of(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lif_frame_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : lif_frame_assembler
//  Description : Collects BUS_WIDTH-wide beats into a WIDTH-bit staging
//                register, LSB beat first, and raises pending when the last
//                beat of a frame lands. Pending holds until commit or flush.
//  Ports       : clk, reset (async, active-high)
//                beat_valid_i  accepted beat for this assembler
//                beat_data_i   beat payload
//                commit_i      consumer took the frame; clears pending
//                flush_i       drop partial and pending frame
//                frame_data_o  staging register contents
//                pending_o     a complete frame is waiting
//  Revision    : 1.0  initial release
// ============================================================================
module lif_frame_assembler
    import lif_synapse_loader_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 beat_valid_i,
    input  logic [BUS_WIDTH-1:0] beat_data_i,
    input  logic                 commit_i,
    input  logic                 flush_i,
    output logic [WIDTH-1:0]     frame_data_o,
    output logic                 pending_o
);

    localparam int BEATS     = beats_of(WIDTH, BUS_WIDTH);
    localparam int BEAT_BITS = beat_bits_of(BEATS);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

    logic [WIDTH-1:0]     staging_q, staging_d;
    logic [BEAT_BITS-1:0] beat_q, beat_d;
    logic                 pending_q, pending_d;

    always_comb begin
        staging_d = staging_q;
        beat_d    = beat_q;
        pending_d = pending_q;
        if (flush_i) begin
            beat_d    = '0;
            pending_d = 1'b0;
        end else begin
            if (commit_i) begin
                pending_d = 1'b0;
            end
            // The top never accepts a beat while any frame is pending, so a
            // beat and a commit never meet on the same assembler.
            if (beat_valid_i) begin
                for (int k = 0; k < BEATS; k++) begin
                    if (beat_q == BEAT_BITS'(k)) begin
                        staging_d[k*BUS_WIDTH +: BUS_WIDTH] = beat_data_i;
                    end
                end
                if (beat_q == LAST_BEAT) begin
                    beat_d    = '0;
                    pending_d = 1'b1;
                end else begin
                    beat_d = beat_q + BEAT_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            staging_q <= '0;
            beat_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            staging_q <= staging_d;
            beat_q    <= beat_d;
            pending_q <= pending_d;
        end
    end

    assign frame_data_o = staging_q;
    assign pending_o    = pending_q;

endmodule
`default_nettype wire

// File: rtl/lif_synapse_loader.sv
`default_nettype none
// ============================================================================
//  Module      : lif_synapse_loader
//  Description : Feeds neuron_lif from a narrow valid/ready byte stream.
//                Input-spike and weight vectors are assembled separately,
//                committed to output shadow registers when not held, and
//                each committed input frame produces a one-cycle enable.
//  Ports       : clk, reset (async, active-high)
//                in_data/in_kind/in_valid/in_ready  beat stream
//                flush   drop partial/pending frames of both kinds
//                hold    freeze commits
//                inputs_out/weights_out  committed vectors
//                neuron_enable  pulse the cycle after an input commit
//                frame_count    committed input frames (wrapping)
//  Revision    : 1.0  initial release
// ============================================================================
module lif_synapse_loader
    import lif_synapse_loader_pkg::*;
#(
    parameter int SYNAPSES   = 32,
    parameter int BUS_WIDTH  = 8,
    parameter int COUNT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BUS_WIDTH-1:0]  in_data,
    input  logic                  in_kind,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic                  hold,
    output logic [SYNAPSES-1:0]   inputs_out,
    output logic [SYNAPSES-1:0]   weights_out,
    output logic                  neuron_enable,
    output logic [COUNT_BITS-1:0] frame_count
);

    generate
        if ((SYNAPSES % BUS_WIDTH) != 0) begin : g_bad_width
            $error("lif_synapse_loader: SYNAPSES must be a multiple of BUS_WIDTH");
        end
    endgenerate

    logic                  accept;
    logic                  commit_ok;
    logic                  inputs_pending, weights_pending;
    logic [SYNAPSES-1:0]   staging_i, staging_w;
    logic                  commit_i, commit_w;

    logic [SYNAPSES-1:0]   inputs_q, inputs_d;
    logic [SYNAPSES-1:0]   weights_q, weights_d;
    logic                  enable_q, enable_d;
    logic [COUNT_BITS-1:0] count_q, count_d;

    // Any pending frame stalls the whole stream so a frame can never be
    // overwritten before it has been committed.
    assign in_ready  = !inputs_pending && !weights_pending && !flush;
    assign accept    = in_valid && in_ready;
    assign commit_ok = !hold && !flush;
    assign commit_i  = commit_ok && inputs_pending;
    assign commit_w  = commit_ok && weights_pending;

    lif_frame_assembler #(
        .WIDTH     (SYNAPSES),
        .BUS_WIDTH (BUS_WIDTH)
    ) u_asm_inputs (
        .clk          (clk),
        .reset        (reset),
        .beat_valid_i (accept && (in_kind == KIND_INPUTS)),
        .beat_data_i  (in_data),
        .commit_i     (commit_i),
        .flush_i      (flush),
        .frame_data_o (staging_i),
        .pending_o    (inputs_pending)
    );

    lif_frame_assembler #(
        .WIDTH     (SYNAPSES),
        .BUS_WIDTH (BUS_WIDTH)
    ) u_asm_weights (
        .clk          (clk),
        .reset        (reset),
        .beat_valid_i (accept && (in_kind == KIND_WEIGHTS)),
        .beat_data_i  (in_data),
        .commit_i     (commit_w),
        .flush_i      (flush),
        .frame_data_o (staging_w),
        .pending_o    (weights_pending)
    );

    always_comb begin
        inputs_d  = inputs_q;
        weights_d = weights_q;
        count_d   = count_q;
        // Recomputed every edge: a pulse already high lasts its one cycle
        // regardless of flush, and no new pulse is started without a commit.
        enable_d  = commit_i;
        if (commit_w) begin
            weights_d = staging_w;
        end
        if (commit_i) begin
            inputs_d = staging_i;
            count_d  = count_q + COUNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inputs_q  <= '0;
            weights_q <= '0;
            enable_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            inputs_q  <= inputs_d;
            weights_q <= weights_d;
            enable_q  <= enable_d;
            count_q   <= count_d;
        end
    end

    assign inputs_out    = inputs_q;
    assign weights_out   = weights_q;
    assign neuron_enable = enable_q;
    assign frame_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_lif_synapse_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lif_synapse_loader
//  Description : Self-checking bench for lif_synapse_loader (32 synapses,
//                byte stream). Fixed vector table, directed corner-case
//                sequences and random traffic, all compared each cycle with
//                a frame-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lif_synapse_loader;

    localparam int SYN = 32;
    localparam int BW  = 8;
    localparam int CB  = 8;
    localparam int NB  = SYN / BW;

    logic           clk = 1'b0;
    logic           reset;
    logic [BW-1:0]  in_data;
    logic           in_kind, in_valid, in_ready, flush, hold;
    logic [SYN-1:0] inputs_out, weights_out;
    logic           neuron_enable;
    logic [CB-1:0]  frame_count;

    lif_synapse_loader #(.SYNAPSES(SYN), .BUS_WIDTH(BW), .COUNT_BITS(CB)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_kind       (in_kind),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush         (flush),
        .hold          (hold),
        .inputs_out    (inputs_out),
        .weights_out   (weights_out),
        .neuron_enable (neuron_enable),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model (frame level) ----------------
    typedef logic [7:0] bq_t[$];
    bq_t            qi, qw;           // beats collected so far, per kind
    logic [SYN-1:0] m_si, m_sw;       // completed frames awaiting commit
    bit             mpi, mpw;
    logic [SYN-1:0] m_i, m_w;
    bit             m_en;
    int             m_cnt;
    logic           last_ready;

    function automatic logic [SYN-1:0] pack(input bq_t q);
        logic [SYN-1:0] v = '0;
        for (int k = 0; k < NB; k++) v = v | ({{(SYN-8){1'b0}}, q[k]} << (8*k));
        return v;
    endfunction

    task automatic model_reset();
        qi.delete(); qw.delete();
        m_si = '0; m_sw = '0; mpi = 0; mpw = 0;
        m_i = '0; m_w = '0; m_en = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic v, input logic k, input logic [7:0] d,
                              input logic h, input logic f);
        bit acc;
        acc  = v && !mpi && !mpw && !f;
        m_en = 0;
        if (f) begin
            qi.delete(); qw.delete(); mpi = 0; mpw = 0;
        end else begin
            if (!h) begin
                if (mpw) begin m_w = m_sw; mpw = 0; end
                if (mpi) begin m_i = m_si; mpi = 0; m_en = 1; m_cnt = (m_cnt + 1) % 256; end
            end
            if (acc) begin
                if (k == 1'b0) begin
                    qi.push_back(d);
                    if (qi.size() == NB) begin m_si = pack(qi); qi.delete(); mpi = 1; end
                end else begin
                    qw.push_back(d);
                    if (qw.size() == NB) begin m_sw = pack(qw); qw.delete(); mpw = 1; end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check in_ready before the edge, advance the
    // model, then check all registered outputs just after the edge.
    task automatic cycle(input logic v, input logic k, input logic [7:0] d,
                         input logic h, input logic f);
        in_valid = v; in_kind = k; in_data = d; hold = h; flush = f;
        #1;
        last_ready = in_ready;
        chk("in_ready", {31'b0, in_ready}, {31'b0, (!mpi && !mpw && !f)});
        model_edge(v, k, d, h, f);
        @(posedge clk);
        #1;
        chk("inputs_out", inputs_out, m_i);
        chk("weights_out", weights_out, m_w);
        chk("neuron_enable", {31'b0, neuron_enable}, {31'b0, m_en});
        chk("frame_count", {24'b0, frame_count}, m_cnt[31:0]);
    endtask

    task automatic send_beat(input logic k, input logic [7:0] d, input logic h);
        for (int t = 0; t < 20; t++) begin
            cycle(1'b1, k, d, h, 1'b0);
            if (last_ready) return;
        end
        total++; bad++;
        $display("FAIL beat_accept_timeout actual=not_accepted required=accepted");
    endtask

    task automatic send_frame(input logic k, input logic [31:0] vec);
        for (int b = 0; b < NB; b++) send_beat(k, vec[8*b +: 8], 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Reset asserted between edges; outputs must clear with no clock edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1; in_valid = 1'b0;
        #1;
        chk({tag, "_inputs_out"}, inputs_out, 32'h0);
        chk({tag, "_weights_out"}, weights_out, 32'h0);
        chk({tag, "_enable"}, {31'b0, neuron_enable}, 32'h0);
        chk({tag, "_count"}, {24'b0, frame_count}, 32'h0);
        model_reset();
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic v; logic k; logic [7:0] d; logic h; logic f;
        logic rdy; logic en; logic [31:0] iout; logic [31:0] wout; logic [7:0] cnt;
    } vec_t;
    vec_t tbl[11];

    initial begin
        int pulses, base, wf_ok;

        // Weight frame then input frame from reset.
        tbl[0]  = '{1,1,8'h11,0,0, 1,0,32'h0,        32'h0,        8'd0};
        tbl[1]  = '{1,1,8'h22,0,0, 1,0,32'h0,        32'h0,        8'd0};
        tbl[2]  = '{1,1,8'h33,0,0, 1,0,32'h0,        32'h0,        8'd0};
        tbl[3]  = '{1,1,8'h44,0,0, 1,0,32'h0,        32'h0,        8'd0};
        tbl[4]  = '{0,0,8'h00,0,0, 0,0,32'h0,        32'h44332211, 8'd0};
        tbl[5]  = '{1,0,8'hAA,0,0, 1,0,32'h0,        32'h44332211, 8'd0};
        tbl[6]  = '{1,0,8'hBB,0,0, 1,0,32'h0,        32'h44332211, 8'd0};
        tbl[7]  = '{1,0,8'hCC,0,0, 1,0,32'h0,        32'h44332211, 8'd0};
        tbl[8]  = '{1,0,8'hDD,0,0, 1,0,32'h0,        32'h44332211, 8'd0};
        tbl[9]  = '{0,0,8'h00,0,0, 0,1,32'hDDCCBBAA, 32'h44332211, 8'd1};
        tbl[10] = '{0,0,8'h00,0,0, 1,0,32'hDDCCBBAA, 32'h44332211, 8'd1};

        reset = 1'b1; in_valid = 0; in_kind = 0; in_data = 0; hold = 0; flush = 0;
        model_reset();
        #12 reset = 1'b0;
        @(posedge clk); #1;
        chk("reset_ready", {31'b0, in_ready}, 32'h1);
        chk("reset_inputs", inputs_out, 32'h0);
        chk("reset_count", {24'b0, frame_count}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].v, tbl[i].k, tbl[i].d, tbl[i].h, tbl[i].f);
            chk($sformatf("tbl%0d_ready", i), {31'b0, last_ready}, {31'b0, tbl[i].rdy});
            chk($sformatf("tbl%0d_en", i), {31'b0, neuron_enable}, {31'b0, tbl[i].en});
            chk($sformatf("tbl%0d_in", i), inputs_out, tbl[i].iout);
            chk($sformatf("tbl%0d_w", i), weights_out, tbl[i].wout);
            chk($sformatf("tbl%0d_cnt", i), {24'b0, frame_count}, {24'b0, tbl[i].cnt});
        end

        // Hold over the last input beat: no pulse while held, one after.
        pulses = 0;
        send_beat(0, 8'h01, 0); send_beat(0, 8'h02, 0); send_beat(0, 8'h03, 0);
        send_beat(0, 8'h04, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 8'h55, 1, 0);
            chk("hold_ready", {31'b0, last_ready}, 32'h0);
            pulses += neuron_enable;
        end
        chk("hold_no_pulse", pulses, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 8'h00, 0, 0);
            pulses += neuron_enable;
        end
        chk("hold_one_pulse", pulses, 1);
        chk("hold_inputs", inputs_out, 32'h04030201);

        // Interleaved kinds: weights commit first, pulse sees new weights.
        wf_ok = 0;
        send_beat(0, 8'h5A, 0); send_beat(0, 8'h6B, 0);
        for (int i = 0; i < NB; i++) send_beat(1, 8'hF0, 0);
        send_beat(0, 8'h7C, 0); send_beat(0, 8'h8D, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 8'h00, 0, 0);
            if (neuron_enable) begin
                wf_ok = 1;
                chk("interleave_weights", weights_out, 32'hF0F0F0F0);
                chk("interleave_inputs", inputs_out, 32'h8D7C6B5A);
            end
        end
        chk("interleave_pulse_seen", wf_ok, 1);

        // Flush mid-frame.
        base = m_cnt;
        send_beat(0, 8'hE1, 0); send_beat(0, 8'hE2, 0); send_beat(0, 8'hE3, 0);
        cycle(1, 0, 8'hFF, 1, 1);
        chk("flush_ready", {31'b0, last_ready}, 32'h0);
        send_frame(0, 32'h04030201);
        chk("flush_inputs", inputs_out, 32'h04030201);
        chk("flush_count", {24'b0, frame_count}, (base + 1) % 256);

        // Async reset mid-frame, then a clean frame afterwards.
        send_beat(0, 8'h99, 0); send_beat(0, 8'h98, 0);
        async_reset("rst_mid");
        send_frame(0, 32'hA1B2C3D4);
        chk("post_reset_inputs", inputs_out, 32'hA1B2C3D4);

        // Counter to 255, reset there, then a full wrap.
        while (m_cnt != 255) send_frame(0, $urandom);
        chk("count_255", {24'b0, frame_count}, 32'd255);
        async_reset("rst_255");
        for (int i = 0; i < 256; i++) send_frame(0, $urandom);
        chk("count_wrap", {24'b0, frame_count}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
